// File: rtl/gbe_over_monitor.sv
// GbE TX overflow monitor: tracks overflow episodes with an IDLE/OVER/RECOVER FSM
// and publishes sticky flags, state and saturating event counters as one status word.
module gbe_over_monitor #(
    parameter int unsigned RECOVER_CYCLES = 64
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        gbe_tx_overflow,
    input  logic        gbe_tx_afull,
    input  logic        clr,
    output logic [31:0] user_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OVER    = 2'b01,
        ST_RECOVER = 2'b10,
        ST_BAD     = 2'b11
    } state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(RECOVER_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        ovr_d_q;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [11:0] rec_cnt_q, rec_cnt_d;
    logic        sticky_ovf_q, sticky_ovf_d;
    logic        sticky_afull_q, sticky_afull_d;
    logic        ovf_event;
    logic        rec_exit;

    assign ovf_event = gbe_tx_overflow & ~ovr_d_q;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rec_exit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ovf_event) state_d = ST_OVER;
            end
            ST_OVER: begin
                if (!gbe_tx_overflow) begin
                    state_d = ST_RECOVER;
                    timer_d = TIMER_LOAD;
                end
            end
            ST_RECOVER: begin
                if (ovf_event) begin
                    state_d = ST_OVER;
                end else if (gbe_tx_afull) begin
                    timer_d = TIMER_LOAD;
                end else if (timer_q == '0) begin
                    state_d  = ST_IDLE;
                    rec_exit = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // clr wipes the old value first, so same-cycle events still land on top of zero
    always_comb begin
        ovf_cnt_d = clr ? '0 : ovf_cnt_q;
        if (ovf_event && ovf_cnt_d != '1) ovf_cnt_d = ovf_cnt_d + 16'd1;
        rec_cnt_d = clr ? '0 : rec_cnt_q;
        if (rec_exit && rec_cnt_d != '1) rec_cnt_d = rec_cnt_d + 12'd1;
        sticky_ovf_d   = (sticky_ovf_q & ~clr) | ovf_event;
        sticky_afull_d = (sticky_afull_q & ~clr) | gbe_tx_afull;
    end

    // ovr_d resets high so a level already asserted at reset release is not an event
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ovr_d_q        <= 1'b1;
            ovf_cnt_q      <= '0;
            rec_cnt_q      <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_afull_q <= 1'b0;
        end else begin
            ovr_d_q        <= gbe_tx_overflow;
            ovf_cnt_q      <= ovf_cnt_d;
            rec_cnt_q      <= rec_cnt_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_afull_q <= sticky_afull_d;
        end
    end

    always_comb begin
        user_data_out = {sticky_ovf_q, sticky_afull_q, state_q, rec_cnt_q, ovf_cnt_q};
    end

endmodule

// File: tb/tb_gbe_over_monitor.sv
// Directed bench for gbe_over_monitor: a behavioural status-word model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_gbe_over_monitor;

    localparam int unsigned RC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ovf = 1'b0;
    logic        afull = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] user_data_out;

    int vectors = 0;
    int miscompares = 0;
    bit en = 1'b0;

    gbe_over_monitor #(.RECOVER_CYCLES(RC)) dut (
        .user_clk        (clk),
        .user_rst        (rst),
        .gbe_tx_overflow (ovf),
        .gbe_tx_afull    (afull),
        .clr             (clr),
        .user_data_out   (user_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: state 0=IDLE 1=OVER 2=RECOVER
    int          m_state = 0;
    int          m_timer = 0;
    int          m_ocnt = 0;
    int          m_rcnt = 0;
    bit          m_so = 1'b0;
    bit          m_sa = 1'b0;
    bit          m_prev = 1'b1;
    logic [31:0] m_exp = '0;

    always @(posedge clk) begin
        bit ev;
        bit done;
        if (rst) begin
            m_state = 0; m_timer = 0; m_ocnt = 0; m_rcnt = 0;
            m_so = 1'b0; m_sa = 1'b0; m_prev = 1'b1;
        end else begin
            ev   = ovf && !m_prev;
            done = 1'b0;
            if (m_state == 0) begin
                if (ev) m_state = 1;
            end else if (m_state == 1) begin
                if (!ovf) begin m_state = 2; m_timer = RC - 1; end
            end else begin
                if (ev) m_state = 1;
                else if (afull) m_timer = RC - 1;
                else if (m_timer == 0) begin m_state = 0; done = 1'b1; end
                else m_timer = m_timer - 1;
            end
            if (clr) begin m_ocnt = 0; m_rcnt = 0; m_so = 1'b0; m_sa = 1'b0; end
            if (ev) begin m_so = 1'b1; if (m_ocnt < 65535) m_ocnt = m_ocnt + 1; end
            if (afull) m_sa = 1'b1;
            if (done && m_rcnt < 4095) m_rcnt = m_rcnt + 1;
            m_prev = ovf;
        end
        m_exp = {m_so, m_sa, 2'(m_state), 12'(m_rcnt), 16'(m_ocnt)};
    end

    always @(posedge clk) begin
        #1;
        if (en) begin
            vectors++;
            if (user_data_out !== m_exp) begin
                miscompares++;
                $display("FAIL model t=%0t: got %h expected %h", $time, user_data_out, m_exp);
            end
        end
    end

    task automatic cyc(input logic o, input logic a, input logic c, input logic r);
        @(negedge clk);
        ovf = o; afull = a; clr = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] exp);
        vectors++;
        if (user_data_out !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, user_data_out, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cyc(0, 0, 0, 1);
        en = 1'b1;
        cyc(0, 0, 0, 1);
        chk("reset", 32'h0000_0000);

        // single pulse, full quiet recovery
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("pulse_over", 32'h9000_0001);
        cyc(0, 0, 0, 0);
        chk("pulse_recover", 32'hA000_0001);
        repeat (RC - 1) cyc(0, 0, 0, 0);
        chk("recover_last", 32'hA000_0001);
        cyc(0, 0, 0, 0);
        chk("recover_exit", 32'h8001_0001);

        // afull extends recovery
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        repeat (10) cyc(0, 1, 0, 0);
        n = 0;
        do begin
            cyc(0, 0, 0, 0);
            n++;
        end while (user_data_out[29:28] == 2'b10 && n < 200);
        chk_int("afull_recover_len", n, 64);
        chk("afull_exit", 32'hC002_0002);

        // clr interactions
        cyc(0, 0, 1, 0);
        chk("clr", 32'h0000_0000);
        repeat (5) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("count5", 32'hA000_0005);
        cyc(1, 0, 1, 0);
        chk("clr_with_event", 32'h9000_0001);
        cyc(0, 1, 1, 0);
        chk("clr_with_afull", 32'h6000_0000);
        repeat (RC - 1) cyc(0, 0, 0, 0);
        chk("recover_hold", 32'h6000_0000);
        cyc(0, 0, 1, 0);
        chk("clr_with_exit", 32'h0001_0000);

        // saturation: count a few edges, preload near full, then overrun
        repeat (20) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk_int("count20", int'(user_data_out[15:0]), 20);
        @(negedge clk);
        ovf = 1'b0; afull = 1'b0; clr = 1'b0; rst = 1'b0;
        force dut.ovf_cnt_q = 16'hFFFA;
        m_ocnt = 16'hFFFA;
        @(posedge clk);
        @(negedge clk);
        release dut.ovf_cnt_q;
        repeat (10) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk_int("sat", int'(user_data_out[15:0]), 16'hFFFF);
        repeat (4) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk_int("sat_hold", int'(user_data_out[15:0]), 16'hFFFF);

        // overflow high across reset release
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0);
        chk("held_through_reset", 32'h0000_0000);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rise_after_reset", 32'h9000_0001);
        repeat (3) cyc(1, 0, 0, 0);
        chk("level_held", 32'h9000_0001);

        // reset mid-RECOVER and mid-OVER
        cyc(0, 0, 0, 0);
        chk("enter_recover", 32'hA000_0001);
        repeat (33) cyc(0, 0, 0, 0);
        chk_int("model_timer30", m_timer, 30);
        cyc(0, 0, 0, 1);
        chk("reset_mid_recover", 32'h0000_0000);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("over_again", 32'h9000_0001);
        cyc(1, 1, 1, 1);
        chk("reset_priority", 32'h0000_0000);
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
